// File: rtl/snn_axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns one command into one AXI4-Lite read or write,
// returns a single response beat, and abandons the bus if the slave hangs.
module snn_axi_lite_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
  output logic                            timeout_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
  // One spare bit above what TIMEOUT_CYCLES needs so the increment never wraps.
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                          state_q, state_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            bready_q, bready_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]               wstrb_q, wstrb_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                      rsp_resp_q, rsp_resp_d;
  logic                            timeout_err_q, timeout_err_d;
  logic [WDOG_W-1:0]               wdog_q, wdog_d;
  logic [WDOG_W-1:0]               wdog_inc;
  logic                            wdog_fire;
  logic                            abandon;
  logic                            aw_pending, w_pending;

  assign wdog_inc  = wdog_q + 1'b1;
  // Fires in the cycle whose increment reaches the limit, so the bus is
  // held for exactly TIMEOUT_CYCLES cycles before being abandoned.
  assign wdog_fire = (TIMEOUT_CYCLES != 0) && (wdog_inc >= WDOG_LIMIT);

  // Next-state and output-register logic; a completing handshake beats the watchdog.
  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    timeout_err_d = timeout_err_q;
    wdog_d        = wdog_q;
    abandon       = 1'b0;
    aw_pending    = awvalid_q && !M_AXI_AWREADY;
    w_pending     = wvalid_q && !M_AXI_WREADY;

    if ((state_q == WR || state_q == WR_RESP || state_q == RD_ADDR || state_q == RD_DATA)
        && (wdog_q != WDOG_LIMIT)) begin
      wdog_d = wdog_inc;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          wdog_d  = '0;
          if (cmd_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!aw_pending && !w_pending) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end else if (wdog_fire) begin
          abandon = 1'b1;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID && bready_q) begin
          rsp_resp_d  = M_AXI_BRESP;
          rsp_rdata_d = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (wdog_fire) begin
          abandon = 1'b1;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else if (wdog_fire) begin
          abandon = 1'b1;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID && rready_q) begin
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (wdog_fire) begin
          abandon = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abandon) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_resp_d    = 2'b11;
      rsp_rdata_d   = '0;
      rsp_valid_d   = 1'b1;
      timeout_err_d = 1'b1;
      state_d       = RSP;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      timeout_err_q <= timeout_err_d;
      wdog_q        <= wdog_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign timeout_err   = timeout_err_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_snn_axi_lite_cmd_master.sv
// Bench for snn_axi_lite_cmd_master: directed latency/stall/timeout/reset cases
// plus randomized traffic against a word-memory reference model.
module tb_snn_axi_lite_cmd_master;

  localparam int TO = 16;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout_err;
  logic [15:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  snn_axi_lite_cmd_master #(
    .C_M_AXI_ADDR_WIDTH(16),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy), .timeout_err(timeout_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int checks = 0;
  int failures = 0;

  // Reference model memory and the slave's own memory (word indexed by addr[7:2]).
  logic [31:0] ref_mem [64];
  logic [31:0] slv_mem [64];

  // Per-transaction observations (cycle numbers relative to the cmd handshake).
  int aw_cyc, w_cyc, ar_cyc, b_cyc, r_cyc, rsp_cyc;
  int awv_n, wv_n, arv_n, rspv_n;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic clear_slave();
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0;
    M_AXI_RDATA = 0; M_AXI_RRESP = 0; rsp_ready = 0;
  endtask

  // One command through the DUT with a cycle-driven slave. Called and returns at posedge+1.
  task automatic run_txn(input string tag, input bit wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int aw_dly, input int w_dly, input int ar_dly,
                         input int resp_dly, input int rsp_dly, input logic [1:0] slv_resp,
                         input bit dead, input bit rst_mid);
    logic [31:0] exp_rdata, first_rdata, wdata_cap;
    logic [1:0]  exp_resp, first_resp;
    logic [15:0] awaddr_cap, araddr_cap;
    logic [3:0]  wstrb_cap;
    int cyc, aw_n, w_n, ar_n, b_n, r_n, bwait, rwait;
    bit cmd_done, finished, wrote, bad_stable, bad_rsp, bad_ready;
    bit armed_b, armed_r, cmd_hs, rsp_hs, inject;

    if (dead) begin
      exp_rdata = 0; exp_resp = 2'b11;
    end else if (wr) begin
      ref_mem[addr[7:2]] = merge_bytes(ref_mem[addr[7:2]], wdata, wstrb);
      exp_rdata = 0; exp_resp = slv_resp;
    end else begin
      exp_rdata = ref_mem[addr[7:2]]; exp_resp = slv_resp;
    end

    aw_cyc = -1; w_cyc = -1; ar_cyc = -1; b_cyc = -1; r_cyc = -1; rsp_cyc = -1;
    awv_n = 0; wv_n = 0; arv_n = 0; rspv_n = 0;
    cyc = 0; aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0; bwait = 0; rwait = 0;
    cmd_done = 0; finished = 0; wrote = 0; bad_stable = 0; bad_rsp = 0; bad_ready = 0;
    first_rdata = 0; first_resp = 0; awaddr_cap = 0; araddr_cap = 0; wdata_cap = 0; wstrb_cap = 0;

    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;

    for (int it = 0; it < 300; it++) begin
      if (cmd_done) cyc++;
      armed_b = (aw_n > 0) && (w_n > 0);
      armed_r = (ar_n > 0);
      M_AXI_AWREADY = !dead && M_AXI_AWVALID && (awv_n >= aw_dly);
      M_AXI_WREADY  = !dead && M_AXI_WVALID && (wv_n >= w_dly);
      M_AXI_ARREADY = !dead && M_AXI_ARVALID && (arv_n >= ar_dly);
      M_AXI_BVALID  = armed_b && (b_n == 0) && (bwait >= resp_dly);
      M_AXI_BRESP   = M_AXI_BVALID ? slv_resp : 2'($urandom);
      M_AXI_RVALID  = armed_r && (r_n == 0) && (rwait >= resp_dly);
      M_AXI_RDATA   = M_AXI_RVALID ? slv_mem[araddr_cap[7:2]] : $urandom;
      M_AXI_RRESP   = M_AXI_RVALID ? slv_resp : 2'($urandom);
      rsp_ready     = rsp_valid && (rspv_n >= rsp_dly);
      inject        = rst_mid && M_AXI_BREADY;
      if (inject) begin
        S_AXI_ARESETN = 0;
        M_AXI_BVALID = 0;
      end

      if (cmd_done && cmd_ready) bad_ready = 1;
      if (M_AXI_AWVALID && M_AXI_AWADDR !== addr) bad_stable = 1;
      if (M_AXI_WVALID && (M_AXI_WDATA !== wdata || M_AXI_WSTRB !== wstrb)) bad_stable = 1;
      if (M_AXI_ARVALID && M_AXI_ARADDR !== addr) bad_stable = 1;
      if (rsp_valid) begin
        if (rspv_n == 0) begin
          rsp_cyc = cyc; first_rdata = rsp_rdata; first_resp = rsp_resp;
        end else if (rsp_rdata !== first_rdata || rsp_resp !== first_resp) begin
          bad_rsp = 1;
        end
      end

      cmd_hs = cmd_valid && cmd_ready;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_n++; aw_cyc = cyc; awaddr_cap = M_AXI_AWADDR; end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_n++; w_cyc = cyc; wdata_cap = M_AXI_WDATA; wstrb_cap = M_AXI_WSTRB;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_n++; ar_cyc = cyc; araddr_cap = M_AXI_ARADDR; end
      if (M_AXI_BVALID && M_AXI_BREADY) begin b_n++; b_cyc = cyc; end
      if (M_AXI_RVALID && M_AXI_RREADY) begin r_n++; r_cyc = cyc; end
      rsp_hs = rsp_valid && rsp_ready;
      if (!wrote && aw_n > 0 && w_n > 0) begin
        slv_mem[awaddr_cap[7:2]] = merge_bytes(slv_mem[awaddr_cap[7:2]], wdata_cap, wstrb_cap);
        wrote = 1;
      end
      if (M_AXI_AWVALID) awv_n++;
      if (M_AXI_WVALID)  wv_n++;
      if (M_AXI_ARVALID) arv_n++;
      if (rsp_valid)     rspv_n++;
      if (armed_b) bwait++;
      if (armed_r) rwait++;

      @(posedge S_AXI_ACLK); #1;

      if (cmd_hs) begin
        cmd_done = 1; cyc = 0; cmd_valid = 0;
        cmd_addr = 16'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom); cmd_write = 1'($urandom);
      end
      if (inject) begin
        S_AXI_ARESETN = 1; finished = 1; break;
      end
      if (rsp_hs) begin
        finished = 1; break;
      end
    end
    clear_slave();

    check_eq({tag, "_completed"}, finished, 1);
    if (rst_mid) begin
      check_eq({tag, "_rst_valids"},
               {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid}, 0);
      check_eq({tag, "_rst_cmd_ready"}, cmd_ready, 1);
      check_eq({tag, "_rst_busy"}, busy, 0);
    end else begin
      if (wr) begin
        check_eq({tag, "_aw_count"}, aw_n, 1);
        check_eq({tag, "_w_count"}, w_n, 1);
        check_eq({tag, "_awaddr"}, awaddr_cap, addr);
        check_eq({tag, "_wdata"}, {wstrb_cap, wdata_cap}, {wstrb, wdata});
      end else begin
        check_eq({tag, "_ar_count"}, ar_n, dead ? 0 : 1);
        if (!dead) check_eq({tag, "_araddr"}, araddr_cap, addr);
      end
      check_eq({tag, "_rsp_rdata"}, first_rdata, exp_rdata);
      check_eq({tag, "_rsp_resp"}, first_resp, exp_resp);
      check_eq({tag, "_bus_stable"}, bad_stable, 0);
      check_eq({tag, "_rsp_stable"}, bad_rsp, 0);
      check_eq({tag, "_cmd_ready_busy"}, bad_ready, 0);
      check_eq({tag, "_idle_after"}, {busy, cmd_ready}, 2'b01);
    end
    $display("txn %s wr=%0d addr=0x%04h rdata=0x%08h resp=%0d rsp_cyc=%0d", tag, wr, addr,
             first_rdata, first_resp, rsp_cyc);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'(i) * 32'h0101_0101;
      slv_mem[i] = 32'(i) * 32'h0101_0101;
    end
    ref_mem[4] = 32'h0000_002A;
    slv_mem[4] = 32'h0000_002A;

    S_AXI_ARESETN = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    clear_slave();
    repeat (3) @(posedge S_AXI_ACLK);
    #1;
    check_eq("reset_cmd_ready_busy", {cmd_ready, busy}, 2'b10);
    check_eq("reset_valids",
             {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid}, 0);
    check_eq("reset_rsp", {rsp_rdata, rsp_resp, timeout_err}, 0);
    check_eq("reset_addr_data", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB}, 0);
    S_AXI_ARESETN = 1;

    // Zero-wait write: AW/W at 1, B at 2, rsp_valid at 3.
    run_txn("zw_write", 1, 16'h0000, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    check_eq("zw_write_aw_cyc", aw_cyc, 1);
    check_eq("zw_write_w_cyc", w_cyc, 1);
    check_eq("zw_write_b_cyc", b_cyc, 2);
    check_eq("zw_write_rsp_cyc", rsp_cyc, 3);

    // Zero-wait read latency.
    run_txn("zw_read", 0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    check_eq("zw_read_ar_cyc", ar_cyc, 1);
    check_eq("zw_read_r_cyc", r_cyc, 2);
    check_eq("zw_read_rsp_cyc", rsp_cyc, 3);

    // AW early, W late; then the reverse.
    run_txn("aw_first", 1, 16'h0104, 32'hDEAD_BEEF, 4'hF, 0, 4, 0, 0, 0, 2'b00, 0, 0);
    check_eq("aw_first_awv_cycles", awv_n, 1);
    check_eq("aw_first_wv_cycles", wv_n, 5);
    check_eq("aw_first_w_cyc", w_cyc, 5);
    run_txn("w_first", 1, 16'h0209, 32'hCAFE_F00D, 4'h5, 4, 0, 0, 1, 0, 2'b01, 0, 0);
    check_eq("w_first_wv_cycles", wv_n, 1);
    check_eq("w_first_awv_cycles", awv_n, 5);

    // Read with ARREADY after 3 cycles.
    run_txn("slow_ar", 0, 16'h0010, 32'h0, 4'h0, 0, 0, 3, 0, 0, 2'b00, 0, 0);
    check_eq("slow_ar_arv_cycles", arv_n, 4);
    check_eq("slow_ar_ar_cyc", ar_cyc, 4);

    // SLVERR read with rsp_ready held off for 4 cycles.
    run_txn("rsp_stall", 0, 16'h0104, 32'h0, 4'h0, 0, 0, 0, 2, 4, 2'b10, 0, 0);
    check_eq("rsp_stall_valid_cycles", rspv_n, 5);

    // Dead slave: watchdog abandons after TO cycles of ARVALID.
    check_eq("timeout_err_before", timeout_err, 0);
    run_txn("dead_read", 0, 16'h0020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    check_eq("dead_read_arv_cycles", arv_n, TO);
    check_eq("dead_read_timeout_err", timeout_err, 1);
    run_txn("after_timeout", 0, 16'h0020, 32'h0, 4'h0, 0, 0, 1, 1, 1, 2'b00, 0, 0);
    check_eq("timeout_err_sticky", timeout_err, 1);

    // Reset asserted while waiting for BVALID, then normal traffic resumes.
    run_txn("rst_bresp", 1, 16'h0030, 32'h1234_5678, 4'hF, 0, 0, 0, 5, 0, 2'b00, 0, 1);
    check_eq("rst_clears_timeout_err", timeout_err, 0);
    run_txn("post_rst_write", 1, 16'h0034, 32'h8765_4321, 4'hC, 1, 2, 0, 1, 1, 2'b00, 0, 0);
    run_txn("post_rst_read", 0, 16'h0034, 32'h0, 4'h0, 0, 0, 2, 0, 0, 2'b00, 0, 0);

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 40; n++) begin
      run_txn($sformatf("rnd%0d", n), 1'($urandom), 16'($urandom), $urandom, 4'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              2'($urandom_range(0, 2)), 0, 0);
    end
    check_eq("no_spurious_timeout", timeout_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
